// File: rtl/truth_table_sweeper.sv
// Clocked sweep of input codes 0..15 through an external 4-in/N-out function block.
// Each code is held for a settle time, then the returned row is streamed on valid/ready and folded into a signature.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_FUNCS     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 w,
  output logic                 x,
  output logic                 y,
  output logic                 z,
  input  logic [NUM_FUNCS-1:0] f_in,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [3:0]           row_index,
  output logic [NUM_FUNCS-1:0] row_data,
  output logic                 row_last,
  output logic [NUM_FUNCS-1:0] signature,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(SETTLE_CYCLES - 1);

  state_t          state;
  logic [3:0]      code;
  logic [CW-1:0]   count;

  assign {w, x, y, z} = code;

  // Handshake: a row transfers on the rising edge where row_valid && row_ready;
  // row_valid never drops and row_data/row_index never change until that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      code      <= '0;
      count     <= '0;
      row_index <= '0;
      row_data  <= '0;
      signature <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            code      <= '0;
            count     <= '0;
            signature <= '0;
          end
        end
        DRIVE: begin
          if (count == LAST_COUNT) begin
            row_data  <= f_in;
            row_index <= code;
            state     <= HOLD;
          end else begin
            count <= count + CW'(1);
          end
        end
        HOLD: begin
          if (row_ready) begin
            signature <= {signature[NUM_FUNCS-2:0], signature[NUM_FUNCS-1]} ^ row_data;
            // The last code stays on the bus; no wrap back to 0.
            if (row_index == 4'd15) begin
              state <= DONE;
            end else begin
              code  <= code + 4'd1;
              count <= '0;
              state <= DRIVE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign row_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign row_last  = row_valid && (row_index == 4'd15);
  assign state_dbg = state;

endmodule
